maxpool_relu_nch: RTL and testbench

Parametrised successor to the fixed 3-channel 2x2 max-pool + ReLU stage. Takes a raster-order stream of NUM_CH signed conv outputs per pixel and performs non-overlapping POOL_SIZE x POOL_SIZE max pooling with run-time selectable ReLU. Adds valid/ready back-pressure, start-of-frame resync and an end-of-frame marker. Sits between the conv engine and the next conv/FC layer.

---
 rtl/maxpool_relu_nch_if.sv | 25 ++
 rtl/maxpool_relu_nch.sv | 175 +++++++++++++++++
 tb/tb_maxpool_relu_nch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_relu_nch_if.sv
// Stream bundle for maxpool_relu_nch: pixel input side, pooled output side and the ReLU mode select.
// slave is the pooling block's view; master is the view of the logic driving and draining it.
interface maxpool_relu_nch_if #(
    parameter int DATA_W = 42
);
    logic              relu_en;
    logic              in_valid;
    logic              in_ready;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  relu_en, in_valid, in_sof, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output relu_en, in_valid, in_sof, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/maxpool_relu_nch.sv
// NUM_CH-channel POOL_SIZE x POOL_SIZE non-overlapping max pool with run-time ReLU and valid/ready flow.
// Build macro MAXPOOL_CLAMP6_EN adds CLAMP_MAX and turns the ReLU into min(max(v,0),CLAMP_MAX).
module maxpool_relu_nch #(
    parameter int CONV_BIT  = 14,
    parameter int NUM_CH    = 3,
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int POOL_SIZE = 2,
`ifdef MAXPOOL_CLAMP6_EN
    parameter int CLAMP_MAX = 6 << 8,
`endif
    parameter int COORD_BIT = 5
) (
    input  logic              clk,
    input  logic              rst,
    maxpool_relu_nch_if.slave bus
);
    localparam int DATA_W = NUM_CH * CONV_BIT;
    localparam int OUT_W  = IN_WIDTH / POOL_SIZE;
    localparam int OUT_H  = IN_HEIGHT / POOL_SIZE;
    localparam int PH_W   = $clog2(POOL_SIZE);
    localparam int LB_AW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    localparam logic [COORD_BIT-1:0] COL_LAST      = COORD_BIT'(IN_WIDTH - 1);
    localparam logic [COORD_BIT-1:0] ROW_LAST      = COORD_BIT'(IN_HEIGHT - 1);
    localparam logic [COORD_BIT-1:0] PCOL_LAST     = COORD_BIT'(OUT_W - 1);
    localparam logic [COORD_BIT-1:0] POOL_ROW_LAST = COORD_BIT'(OUT_H * POOL_SIZE - 1);
    localparam logic [COORD_BIT:0]   ACT_COLS      = (COORD_BIT + 1)'(OUT_W * POOL_SIZE);
    localparam logic [COORD_BIT:0]   ACT_ROWS      = (COORD_BIT + 1)'(OUT_H * POOL_SIZE);
    localparam logic [PH_W-1:0]      PH_LAST       = PH_W'(POOL_SIZE - 1);

    // Raster position of the next pixel; *_ph track col%P and row%P without a divider.
    logic [COORD_BIT-1:0] col, row, pool_col;
    logic [PH_W-1:0]      col_ph, row_ph;
    logic                 relu_q;

    logic                 out_valid_q, out_last_q;
    logic [DATA_W-1:0]    out_data_q;

    logic                 accept, first_pix, col_active, row_active;
    logic                 col_end, row_end, complete, lb_we, last_pool;
    logic [COORD_BIT-1:0] cur_col, cur_row, cur_pcol;
    logic [PH_W-1:0]      cur_cph, cur_rph;

    logic [DATA_W-1:0]    linebuf [OUT_W];
    logic [DATA_W-1:0]    lb_rd, lb_wr, pooled;
    logic [LB_AW-1:0]     lb_addr;

    // NOTE: in_ready looks only at the output register, never at in_valid, so no combinational loop forms upstream.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    assign accept = bus.in_valid && bus.in_ready;

    // A start-of-frame pixel is processed as if the counters already stood at (0,0).
    assign cur_col  = bus.in_sof ? '0 : col;
    assign cur_row  = bus.in_sof ? '0 : row;
    assign cur_pcol = bus.in_sof ? '0 : pool_col;
    assign cur_cph  = bus.in_sof ? '0 : col_ph;
    assign cur_rph  = bus.in_sof ? '0 : row_ph;

    assign first_pix  = (cur_col == '0) && (cur_row == '0);
    assign col_active = {1'b0, cur_col} < ACT_COLS;
    assign row_active = {1'b0, cur_row} < ACT_ROWS;
    assign col_end    = cur_cph == PH_LAST;
    assign row_end    = cur_rph == PH_LAST;
    assign complete   = accept && col_active && row_active && col_end && row_end;
    assign lb_we      = accept && col_active && row_active && col_end && !row_end;
    assign last_pool  = (cur_row == POOL_ROW_LAST) && (cur_pcol == PCOL_LAST);

    assign lb_addr = cur_pcol[LB_AW-1:0];
    assign lb_rd   = linebuf[lb_addr];

`ifdef MAXPOOL_CLAMP6_EN
    localparam logic signed [CONV_BIT-1:0] CLAMP_V = CONV_BIT'(CLAMP_MAX);
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [CONV_BIT-1:0] pix, hacc, hmax, lb_v, vmax, act;

        assign pix  = bus.in_data[c*CONV_BIT +: CONV_BIT];
        assign lb_v = lb_rd[c*CONV_BIT +: CONV_BIT];

        // Running maxima are seeded by the first sample of each span, so all-negative windows stay exact.
        assign hmax = (cur_cph == '0 || pix > hacc) ? pix : hacc;
        assign vmax = (cur_rph == '0 || hmax > lb_v) ? hmax : lb_v;

`ifdef MAXPOOL_CLAMP6_EN
        always_comb begin
            act = vmax;
            if (relu_q) begin
                if (vmax[CONV_BIT-1]) begin
                    act = '0;
                end else if (vmax > CLAMP_V) begin
                    act = CLAMP_V;
                end
            end
        end
`else
        assign act = (relu_q && vmax[CONV_BIT-1]) ? '0 : vmax;
`endif

        assign lb_wr[c*CONV_BIT +: CONV_BIT]  = vmax;
        assign pooled[c*CONV_BIT +: CONV_BIT] = act;

        always_ff @(posedge clk) begin
            if (rst) begin
                hacc <= '0;
            end else if (accept) begin
                hacc <= hmax;
            end
        end
    end

    // NOTE: the line buffer has no reset; row phase 0 of every pool row rewrites each entry before it is read.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_addr] <= lb_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            pool_col <= '0;
            col_ph   <= '0;
            row_ph   <= '0;
            relu_q   <= 1'b1;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col      <= '0;
                col_ph   <= '0;
                pool_col <= '0;
                if (cur_row == ROW_LAST) begin
                    row    <= '0;
                    row_ph <= '0;
                end else begin
                    row    <= cur_row + 1'b1;
                    row_ph <= row_end ? '0 : cur_rph + 1'b1;
                end
            end else begin
                col    <= cur_col + 1'b1;
                col_ph <= col_end ? '0 : cur_cph + 1'b1;
                row    <= cur_row;
                row_ph <= cur_rph;
                if (col_end && col_active) begin
                    pool_col <= (cur_pcol == PCOL_LAST) ? '0 : cur_pcol + 1'b1;
                end else begin
                    pool_col <= cur_pcol;
                end
            end
            if (first_pix) begin
                relu_q <= bus.relu_en;
            end
        end
    end

    // A completing accept can only occur when the register is empty or draining, so loading wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (complete) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pooled;
            out_last_q  <= last_pool;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_maxpool_relu_nch.sv
// Directed bench for maxpool_relu_nch on a 5x5, 2-channel, 2x2 configuration with a window-max reference model.
// Expected results are queued when the completing pixel is driven and compared when the DUT hands them over.
module tb_maxpool_relu_nch;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int P  = 2;
    localparam int OW = W / P;
    localparam int OH = H / P;
    localparam int CH = 2;
    localparam int CB = 8;
    localparam int DW = CH * CB;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    maxpool_relu_nch_if #(.DATA_W(DW)) bus ();

    maxpool_relu_nch #(
        .CONV_BIT (CB),
        .NUM_CH   (CH),
        .IN_WIDTH (W),
        .IN_HEIGHT(H),
        .POOL_SIZE(P),
        .COORD_BIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_out    = 0;
    exp_t sb [$];
    exp_t mon_e;

    logic signed [CB-1:0] frm [CH][W*H];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: direct max over the 2x2 window in the stored frame, then optional ReLU.
    function automatic logic [DW-1:0] exp_pool(input int pr, input int pc, input bit relu);
        logic [DW-1:0] r;
        r = '0;
        for (int ch = 0; ch < CH; ch++) begin
            logic signed [CB-1:0] m;
            m = frm[ch][(P*pr)*W + P*pc];
            for (int dr = 0; dr < P; dr++) begin
                for (int dc = 0; dc < P; dc++) begin
                    if (frm[ch][(P*pr + dr)*W + P*pc + dc] > m) m = frm[ch][(P*pr + dr)*W + P*pc + dc];
                end
            end
            if (relu && m < 0) m = '0;
            r[ch*CB +: CB] = m;
        end
        return r;
    endfunction

    // Core 4x4 holds 0..15 raster (channel 1 negated); the discarded row/column hold 127.
    task automatic fill_ramp();
        for (int i = 0; i < W*H; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            frm[0][i] = (r < OH*P && c < OW*P) ? CB'(r*4 + c) : CB'(127);
            frm[1][i] = (r < OH*P && c < OW*P) ? CB'(-(r*4 + c)) : CB'(127);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < W*H; i++) begin
            for (int ch = 0; ch < CH; ch++) begin
                frm[ch][i] = ((i / W) >= OH*P || (i % W) >= OW*P) ? CB'(127) : CB'($urandom);
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit sof, input bit comp);
        bit rdy;
        int guard;
        rdy   = 1'b0;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_data  = d;
        while (!rdy && guard < 50) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
        if (comp && rdy) check("latency_1cyc", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic send_frame(input bit relu, input bit sof, input bit flip, input int npix);
        bus.relu_en = relu;
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            bit comp;
            r    = i / W;
            c    = i % W;
            comp = (r % P == P-1) && (c % P == P-1) && (r < OH*P) && (c < OW*P);
            if (comp) begin
                sb.push_back('{data: exp_pool(r / P, c / P, relu), last: (r / P == OH-1) && (c / P == OW-1)});
                n_push++;
            end
            send({frm[1][i], frm[0][i]}, sof && (i == 0), comp);
            if (flip && i == 0) bus.relu_en = !relu;
        end
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_data", 32'(bus.out_data), 32'(mon_e.data));
                check("out_last", 32'(bus.out_last), 32'(mon_e.last));
            end
            n_out++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.relu_en   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Ramp frame with ReLU: channel 0 gives 5,7,13,15, channel 1 is clamped to 0.
        fill_ramp();
        send_frame(1'b1, 1'b1, 1'b0, W*H);
        drain("drain_ramp_relu");
        check("ramp_out_count", 32'(n_out), 32'd4);

        // Same frame, ReLU off at the first pixel; toggling relu_en mid-frame must not matter.
        send_frame(1'b0, 1'b1, 1'b1, W*H);
        drain("drain_ramp_signed");

        // All-negative window {-7,-3,-9,-5}; frame starts by counter wrap, without in_sof.
        fill_random();
        frm[0][0] = -8'sd7;
        frm[0][1] = -8'sd3;
        frm[0][W] = -8'sd9;
        frm[0][W+1] = -8'sd5;
        for (int i = 0; i < W*H; i++) if ((i / W) < OH*P && (i % W) < OW*P) frm[1][i] = -CB'($urandom_range(1, 128));
        send_frame(1'b0, 1'b0, 1'b0, W*H);
        drain("drain_negative");

        // Output stalled for five cycles while the upstream keeps offering pixels.
        fill_random();
        fork
            send_frame(1'b1, 1'b1, 1'b0, W*H);
            begin : stall_proc
                int g;
                logic [DW-1:0] held;
                logic held_last;
                g = 0;
                while (bus.out_valid !== 1'b1 && g < 100) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                check("stall_wait", 32'(bus.out_valid), 32'd1);
                bus.out_ready = 1'b0;
                held      = bus.out_data;
                held_last = bus.out_last;
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk);
                    #1;
                    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    check("stall_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_data_hold", 32'(bus.out_data), 32'(held));
                    check("stall_last_hold", 32'(bus.out_last), 32'(held_last));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_stall");

        // Six pixels of an abandoned frame, then in_sof restarts at what would be pixel 6.
        fill_random();
        send_frame(1'b1, 1'b1, 1'b0, 6);
        fill_random();
        send_frame(1'b0, 1'b1, 1'b0, W*H);
        drain("drain_sof_resync");

        // Reset in the middle of a frame discards the partial windows.
        fill_random();
        send_frame(1'b0, 1'b0, 1'b0, 6);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'd0);
        check("midrst_out_last", 32'(bus.out_last), 32'd0);
        fill_random();
        send_frame(1'b1, 1'b0, 1'b0, W*H);
        drain("drain_after_rst");

        // Random downstream back-pressure across a whole frame.
        fill_random();
        fork
            send_frame(1'($urandom_range(0, 1)), 1'b1, 1'b0, W*H);
            begin
                for (int k = 0; k < 60; k++) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check("total_outputs", 32'(n_out), 32'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
